// File: rtl/ad9512_spi_cfg.sv
// AD9512 SPI configuration master: walks a ROM table of 24-bit write
// frames and shifts each one out MSB-first on a 3-wire write-only bus.
module ad9512_spi_cfg #(
  parameter int CLK_DIV = 4,
  parameter int N_REGS  = 16,
  parameter int IDX_W   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [IDX_W-1:0] cfg_idx,
  input  logic [23:0]      cfg_word,
  output logic             spi_csb,
  output logic             spi_sclk,
  output logic             spi_sdio,
  output logic             busy,
  output logic             done
);

  localparam int PH_W = $clog2(2 * CLK_DIV) > 0 ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [PH_W-1:0]  HALF_M1 = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  GAP_M1  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             start_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [22:0]      sh_q, sh_d;
  logic [4:0]       bit_q, bit_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             csb_q, csb_d;
  logic             sclk_q, sclk_d;
  logic             sdio_q, sdio_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_edge;

  assign start_edge = start & ~start_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      idx_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdio_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      sdio_q  <= sdio_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    csb_d   = csb_q;
    sclk_d  = sclk_q;
    sdio_d  = sdio_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        sh_d    = cfg_word[22:0];
        bit_d   = 5'd23;
        ph_d    = '0;
        csb_d   = 1'b0;
        sclk_d  = 1'b0;
        sdio_d  = cfg_word[23];
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (ph_q == HALF_M1) begin
          ph_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == 5'd0) begin
            sclk_d  = 1'b0;
            csb_d   = 1'b1;
            sdio_d  = 1'b0;
            state_d = S_GAP;
          end else begin
            // data moves on the falling edge; slave samples on the rise
            sclk_d = 1'b0;
            sdio_d = sh_q[22];
            sh_d   = {sh_q[21:0], 1'b0};
            bit_d  = bit_q - 5'd1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_GAP: begin
        if (ph_q == GAP_M1) begin
          ph_d = '0;
          if (idx_q == LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_idx  = idx_q;
  assign spi_csb  = csb_q;
  assign spi_sclk = sclk_q;
  assign spi_sdio = sdio_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
